// File: rtl/fft_lane_code_encoder_pkg.sv
// Shared lane-code definitions for the FFT lane-select encoder and decoder.
// Package name is fft_lane_pkg so the decoder side can import the same constants.
package fft_lane_pkg;

    typedef logic [2:0] lane_code_t;

    typedef enum logic {IDLE, BUSY} lane_enc_state_e;

    localparam lane_code_t LANE_CODE_L0   = 3'b000;
    localparam lane_code_t LANE_CODE_L1   = 3'b001;
    localparam lane_code_t LANE_CODE_L2   = 3'b100;
    localparam lane_code_t LANE_CODE_IDLE = 3'b010;

    function automatic lane_code_t lane_code(input logic [1:0] idx);
        case (idx)
            2'd0:    lane_code = LANE_CODE_L0;
            2'd1:    lane_code = LANE_CODE_L1;
            2'd2:    lane_code = LANE_CODE_L2;
            default: lane_code = LANE_CODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fft_lane_code_encoder_arb3.sv
// Combinational 3-way arbiter; round-robin from ptr+1 when FFT_LANE_ENC_RR_EN
// is defined, otherwise fixed priority lane0 > lane1 > lane2.
module lane_arb3
    import fft_lane_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] grant_idx
);

`ifdef FFT_LANE_ENC_RR_EN
    logic [1:0] start;
    logic [2:0] cand;

    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        cand      = 3'd0;
        start     = (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
        // Walk from the farthest candidate down so the nearest requester wins last.
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, start} + 3'(k);
            if (cand >= 3'd3)
                cand = cand - 3'd3;
            if (req[cand[1:0]]) begin
                grant     = 3'b001 << cand[1:0];
                grant_idx = cand[1:0];
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant     = 3'b000;
        grant_idx = 2'd0;
        if (req[0]) begin
            grant     = 3'b001;
            grant_idx = 2'd0;
        end else if (req[1]) begin
            grant     = 3'b010;
            grant_idx = 2'd1;
        end else if (req[2]) begin
            grant     = 3'b100;
            grant_idx = 2'd2;
        end
    end
`endif

endmodule

// File: rtl/fft_lane_code_encoder.sv
// Three-lane arbiter/encoder feeding the lane-select decoder with a registered
// valid/ready stream. Round-robin arbitration is enabled by FFT_LANE_ENC_RR_EN.
module fft_lane_code_encoder
    import fft_lane_pkg::*;
#(
    parameter type addr_t = logic [9:0],
    parameter int  CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_i,
    input  addr_t [2:0]       addr_i,
    output logic [2:0]        ack_o,
    output lane_code_t        code_o,
    output addr_t             addr_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  xfer_cnt_o
);

    lane_enc_state_e state;
    logic [2:0]      grant;
    logic [1:0]      grant_idx;
    logic [1:0]      ptr_q;
    logic            cap;
    logic            fire;

    assign valid_o = (state == BUSY);
    assign fire    = valid_o && ready_i;
    assign cap     = (!valid_o || ready_i) && (|req_i);
    // No ack may leak out while reset is held, even though valid_o is already low.
    assign ack_o   = (cap && !rst) ? grant : 3'b000;

    lane_arb3 u_arb (
        .req       (req_i),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

`ifdef FFT_LANE_ENC_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= 2'd2;
        else if (cap)
            ptr_q <= grant_idx;
    end
`else
    assign ptr_q = 2'd2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            code_o <= LANE_CODE_IDLE;
            addr_o <= '0;
        end else if (cap) begin
            state  <= BUSY;
            code_o <= lane_code(grant_idx);
            addr_o <= addr_i[grant_idx];
        end else if (fire) begin
            state  <= IDLE;
            code_o <= LANE_CODE_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_cnt_o <= '0;
        else if (fire)
            xfer_cnt_o <= xfer_cnt_o + 1'b1;
    end

endmodule

// File: tb/tb_fft_lane_code_encoder.sv
// Self-checking bench for fft_lane_code_encoder: directed vector table, corner
// sequences, and randomized traffic against a lane-level reference model.
module tb_fft_lane_code_encoder;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req_i;
    logic [2:0][9:0]  addr_i;
    logic [2:0]       ack_o;
    logic [2:0]       code_o;
    logic [9:0]       addr_o;
    logic             valid_o;
    logic             ready_i;
    logic [15:0]      xfer_cnt_o;

    int checks   = 0;
    int failures = 0;

    fft_lane_code_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .ack_o      (ack_o),
        .code_o     (code_o),
        .addr_o     (addr_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .xfer_cnt_o (xfer_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic        ready;
        logic [9:0]  a0, a1, a2;
        logic [2:0]  exp_ack;
        logic        exp_valid;
        logic [2:0]  exp_code;
        logic [9:0]  exp_addr;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [2:0] code_of(input int lane);
        case (lane)
            0:       return 3'b000;
            1:       return 3'b001;
            2:       return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    // Reference model state: what the output register should hold now.
    logic        m_valid;
    logic [2:0]  m_code;
    logic [9:0]  m_addr;
    logic [15:0] m_cnt;
    int          m_last;

    initial begin
        logic [2:0] seq_ack  [5];
        logic [2:0] seq_code [5];
        logic       seq_vld  [5];

        rst     = 1'b1;
        req_i   = 3'b000;
        addr_i  = '0;
        ready_i = 1'b1;
        #12;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            vecs[i] = '{3'b000, 1'b1, 10'h0, 10'h0, 10'h0, 3'b000, 1'b0, 3'b010, 10'h0, 16'd0};
        vecs[5] = '{3'b010, 1'b1, 10'h0, 10'h155, 10'h0, 3'b010, 1'b0, 3'b010, 10'h0,   16'd0};
        vecs[6] = '{3'b000, 1'b1, 10'h0, 10'h0,   10'h0, 3'b000, 1'b1, 3'b001, 10'h155, 16'd0};
        vecs[7] = '{3'b000, 1'b1, 10'h0, 10'h0,   10'h0, 3'b000, 1'b0, 3'b010, 10'h155, 16'd1};

        for (int i = 0; i < 8; i++) begin
            req_i   = vecs[i].req;
            ready_i = vecs[i].ready;
            addr_i  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
            #1;
            chk($sformatf("tbl%0d ack", i),   32'(ack_o),      32'(vecs[i].exp_ack));
            chk($sformatf("tbl%0d valid", i), 32'(valid_o),    32'(vecs[i].exp_valid));
            chk($sformatf("tbl%0d code", i),  32'(code_o),     32'(vecs[i].exp_code));
            chk($sformatf("tbl%0d addr", i),  32'(addr_o),     32'(vecs[i].exp_addr));
            chk($sformatf("tbl%0d cnt", i),   32'(xfer_cnt_o), 32'(vecs[i].exp_cnt));
            @(negedge clk);
        end

        // All lanes requesting, ready always high: back-to-back grants.
        do_reset();
`ifdef FFT_LANE_ENC_RR_EN
        seq_ack  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        seq_code = '{3'b010, 3'b000, 3'b001, 3'b100, 3'b000};
`else
        seq_ack  = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        seq_code = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
        seq_vld = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        req_i   = 3'b111;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("b2b%0d ack", i),   32'(ack_o),   32'(seq_ack[i]));
            chk($sformatf("b2b%0d code", i),  32'(code_o),  32'(seq_code[i]));
            chk($sformatf("b2b%0d valid", i), 32'(valid_o), 32'(seq_vld[i]));
            @(negedge clk);
        end

        // Capture lane2, stall 4 cycles, then release with lane0 waiting.
        do_reset();
        req_i   = 3'b100;
        addr_i  = {10'h3FF, 10'h011, 10'h022};
        ready_i = 1'b1;
        #1;
        chk("stall cap ack", 32'(ack_o), 32'(3'b100));
        @(negedge clk);
        req_i   = 3'b001;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("stall%0d ack", i),  32'(ack_o),  32'(3'b000));
            chk($sformatf("stall%0d code", i), 32'(code_o), 32'(3'b100));
            chk($sformatf("stall%0d addr", i), 32'(addr_o), 32'(10'h3FF));
            @(negedge clk);
        end
        ready_i = 1'b1;
        #1;
        chk("unstall ack", 32'(ack_o), 32'(3'b001));
        @(negedge clk);
        req_i = 3'b000;
        #1;
        chk("unstall code",  32'(code_o),  32'(3'b000));
        chk("unstall addr",  32'(addr_o),  32'(10'h022));
        chk("unstall cnt",   32'(xfer_cnt_o), 32'(16'd1));

        // Reset during a stalled transfer.
        @(negedge clk);
        req_i   = 3'b010;
        ready_i = 1'b0;
        @(negedge clk);
        req_i   = 3'b111;
        #1;
        chk("pre-rst valid", 32'(valid_o), 32'(1'b1));
        rst = 1'b1;
        #1;
        chk("rst valid", 32'(valid_o),    32'(1'b0));
        chk("rst code",  32'(code_o),     32'(3'b010));
        chk("rst cnt",   32'(xfer_cnt_o), 32'(16'd0));
        chk("rst ack",   32'(ack_o),      32'(3'b000));
        @(negedge clk);
        rst     = 1'b0;
        ready_i = 1'b1;
        #1;
        chk("post-rst ack", 32'(ack_o), 32'(3'b001));
        @(negedge clk);

        // Randomized traffic against the lane-level model.
        do_reset();
        m_valid = 1'b0;
        m_code  = 3'b010;
        m_addr  = 10'h0;
        m_cnt   = 16'd0;
        m_last  = 2;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       cap;
            logic       fire;
            int         g;
            int         start;
            logic [2:0] exp_ack;
            req_i   = 3'($urandom_range(0, 7));
            ready_i = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < 3; l++)
                addr_i[l] = 10'($urandom);
            #1;
            chk("rnd valid", 32'(valid_o),    32'(m_valid));
            chk("rnd code",  32'(code_o),     32'(m_code));
            chk("rnd addr",  32'(addr_o),     32'(m_addr));
            chk("rnd cnt",   32'(xfer_cnt_o), 32'(m_cnt));
`ifdef FFT_LANE_ENC_RR_EN
            start = (m_last + 1) % 3;
`else
            start = 0;
`endif
            g = -1;
            for (int k = 0; k < 3; k++)
                if (g < 0 && req_i[(start + k) % 3])
                    g = (start + k) % 3;
            cap     = (!m_valid || ready_i) && (g >= 0);
            fire    = m_valid && ready_i;
            exp_ack = cap ? (3'b001 << g) : 3'b000;
            chk("rnd ack", 32'(ack_o), 32'(exp_ack));
            if (fire)
                m_cnt = m_cnt + 16'd1;
            if (cap) begin
                m_valid = 1'b1;
                m_code  = code_of(g);
                m_addr  = addr_i[g];
                m_last  = g;
            end else if (fire) begin
                m_valid = 1'b0;
                m_code  = 3'b010;
            end
            @(negedge clk);
        end

        // Counter wrap: continuous lane0 traffic fires once per cycle after the first.
        do_reset();
        req_i   = 3'b001;
        ready_i = 1'b1;
        repeat (65536) @(negedge clk);
        #1;
        chk("cnt max", 32'(xfer_cnt_o), 32'(16'hFFFF));
        @(negedge clk);
        #1;
        chk("cnt wrap", 32'(xfer_cnt_o), 32'(16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_lane_code_encoder.md
Name: fft_lane_code_encoder

Overview:
- Transmit-side counterpart of the 3-bit lane-select decoder in the FFT pipeline.
- Arbitrates three requesting lanes, each carrying an addr_t payload, and encodes the winner as the 3-bit lane code that the decoder consumes (000 / 001 / 100).
- Emits code plus payload on a registered valid/ready output, sustaining one transfer per cycle.
- Sits between the butterfly-stage address generators and the lane-select decoder.

Parameters:
- addr_t, logic [9:0], payload type carried per lane (type parameter).
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_i  input  3  per-lane request; held high until that lane's ack_o
- addr_i  input  addr_t [2:0]  per-lane payload, sampled at ack
- ack_o  output  3  one-hot, combinational; high in the capture cycle of the granted lane
- code_o  output  3  registered lane code
- addr_o  output  addr_t  registered payload of the granted lane
- valid_o  output  1  registered output valid
- ready_i  input  1  downstream ready
- xfer_cnt_o  output  CNT_W  count of completed output transfers

Behaviour:
- Reset (async, rst=1):
  - valid_o=0, code_o=3'b010 (decoder default, all strobes low), addr_o=0.
  - ack_o=0, xfer_cnt_o=0, state=IDLE, rr pointer=2 (lane0 wins first).
- Lane codes:
  - lane0=3'b000, lane1=3'b001, lane2=3'b100.
  - Idle/invalid code=3'b010; code_o carries 3'b010 whenever valid_o=0.
- Capture condition: cap = (!valid_o || ready_i) && |req_i.
- On cap:
  - Grant lane g, assert ack_o[g] in the same cycle.
  - Next edge: code_o=code(g), addr_o=addr_i[g], valid_o=1.
  - Latency from req to valid_o is 1 cycle.
- Fire condition: fire = valid_o && ready_i.
  - fire without cap: valid_o→0, code_o→3'b010, addr_o holds its last value.
- Stall: valid_o && !ready_i → code_o/addr_o stable, ack_o=0, requests wait.
- Simultaneous fire and cap: output reloads with the new grant, no bubble. Throughput is 1/cycle.
- States:
  - IDLE (valid_o=0): cap→BUSY; otherwise stay.
  - BUSY (valid_o=1): fire&&cap→BUSY (reload); fire&&!cap→IDLE; !ready_i→BUSY (hold).
- Arbitration:
  - Priority starts at (ptr+1) mod 3, where ptr is the last granted lane.
  - ptr updates only on cap.
- Counter: xfer_cnt_o increments on every fire and wraps from 2^CNT_W-1 to 0.
- Requests deasserted before ack are simply not served; no lane state is retained.
- Reset mid-transfer: the pending output is discarded and no ack is reissued. A requester still holding req_i is re-arbitrated after reset release.

Optional Feature:
- Macro FFT_LANE_ENC_RR_EN.
- Defined: round-robin arbitration as described, ptr register present.
- Undefined: fixed priority lane0 > lane1 > lane2, no ptr register; lane2 may starve.
- All other behaviour is identical in both builds.

Decomposition:
- Package fft_lane_pkg holds:
  - localparams LANE_CODE_L0=3'b000, LANE_CODE_L1=3'b001, LANE_CODE_L2=3'b100, LANE_CODE_IDLE=3'b010.
  - typedef enum logic {IDLE, BUSY} lane_enc_state_e.
  - typedef logic [2:0] lane_code_t.
  - These are shared with the decoder.
- One sub-module, lane_arb3: combinational 3-way arbiter.
  - Inputs req[2:0], ptr[1:0].
  - Outputs grant one-hot[2:0] and grant index.
  - Round-robin or fixed priority, selected by FFT_LANE_ENC_RR_EN.

Test Plan:
- Reset release, req_i=3'b000, ready_i=1 for 5 cycles → valid_o=0, code_o=3'b010, ack_o=0, xfer_cnt_o=0.
- req_i=3'b010 with addr_i[1]=10'h155, ready_i=1 → ack_o=3'b010 in the same cycle; next cycle valid_o=1, code_o=3'b001, addr_o=10'h155; xfer_cnt_o=1 one cycle later.
- req_i=3'b111 held, ready_i=1 (RR build) → ack sequence lane0, lane1, lane2, lane0; code_o sequence 000, 001, 100, 000 back-to-back, valid_o continuously 1.
- Same stimulus, fixed-priority build → ack_o=3'b001 every cycle, code_o stays 3'b000.
- Capture lane2 (addr 10'h3FF), then hold ready_i=0 for 4 cycles with req_i=3'b001 → code_o=3'b100 and addr_o=10'h3FF stable, ack_o=0. Raise ready_i → lane0 acked the same cycle, next code_o=3'b000.
- Stall with valid_o=1, pulse rst for 1 cycle mid-transfer → valid_o=0, code_o=3'b010, xfer_cnt_o=0 immediately. After release with req_i=3'b111, lane0 is granted first.
- Preload the count to 16'hFFFF via 65535 fires, then one more fire → xfer_cnt_o=16'h0000.
